lin_schedule_ctrl: RTL

LIN master schedule-table controller. Stores a small schedule table (frame ID and slot length per entry) and sequences the master frame engine through it, one frame request per slot. It handles wrap-around, slot overruns, insertion of diagnostic frames and go-to-sleep. It sits between the APB register file (enable, frame count, sleep, diagnostic controls) and the master frame engine (request/done handshake).

---
 rtl/lin_schedule_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lin_schedule_ctrl.sv
// LIN master schedule-table controller: walks a small frame table, one frame
// request per slot, with diagnostic/go-to-sleep slot insertion and overrun flagging.
//
// state      | meaning
// IDLE       | schedule stopped, cur_index parked at 0
// LOAD       | pick slot source (sleep > diag > table), clear slot counter
// REQ        | frame_req asserted, waiting for frame_done or slot expiry
// SLOT_WAIT  | frame finished, waiting out the rest of the slot
// SLEEP      | go-to-sleep sent, waiting for wakeup
module lin_schedule_ctrl #(
   parameter int         DEPTH     = 16,
   parameter logic [5:0] DIAG_ID   = 6'h3C,
   parameter logic [7:0] DIAG_SLOT = 8'd20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        cfg_wr_en,
   input  logic [3:0]  cfg_addr,
   input  logic [13:0] cfg_wdata,
   input  logic        en_schedule,
   input  logic [7:0]  nb_of_frames,
   input  logic        diag_req,
   input  logic        sleep_cmd,
   input  logic        wakeup,
   input  logic        frame_done,
   output logic        frame_req,
   output logic [5:0]  frame_id,
   output logic [3:0]  cur_index,
   output logic        busy,
   output logic        sleeping,
   output logic        slot_overrun
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_SLOT_WAIT, S_SLEEP} state_t;

   state_t      state;
   logic [13:0] table_q [DEPTH];
   logic [7:0]  slot_cnt;
   logic [7:0]  slot_len;
   logic        slot_sleep;
   logic        slot_diag;
   logic        pend_sleep;
   logic        pend_diag;
   logic [4:0]  lim;
   logic [4:0]  idx_p1;
   logic [8:0]  cnt_p1;
   logic [13:0] entry;
   logic        overrun_hit;
   logic        slot_end;
   logic        wrap;

   function automatic logic [7:0] eff_len(input logic [7:0] len);
      return (len == 8'd0) ? 8'd1 : len;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else if (cfg_wr_en && (int'(cfg_addr) < DEPTH)) begin
         table_q[cfg_addr[AW-1:0]] <= cfg_wdata;
      end
   end

   always_comb begin
      lim    = (nb_of_frames > 8'(DEPTH)) ? 5'(DEPTH) : nb_of_frames[4:0];
      entry  = table_q[cur_index[AW-1:0]];
      idx_p1 = {1'b0, cur_index} + 5'd1;
      cnt_p1 = {1'b0, slot_cnt} + 9'd1;
      // done wins over an expiring tick in the same cycle
      overrun_hit = (state == S_REQ) && !frame_done && tick && (cnt_p1 >= {1'b0, slot_len});
      slot_end    = overrun_hit || ((state == S_SLOT_WAIT) && (slot_cnt >= slot_len));
      // a diag slot keeps the index, so it only resets when the table shrank below it
      wrap        = slot_diag ? (idx_p1 > lim) : (idx_p1 >= lim);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         frame_req    <= 1'b0;
         frame_id     <= '0;
         cur_index    <= '0;
         busy         <= 1'b0;
         sleeping     <= 1'b0;
         slot_overrun <= 1'b0;
         slot_cnt     <= '0;
         slot_len     <= 8'd1;
         slot_sleep   <= 1'b0;
         slot_diag    <= 1'b0;
         pend_sleep   <= 1'b0;
         pend_diag    <= 1'b0;
      end else begin
         if (tick && (state == S_REQ || state == S_SLOT_WAIT) && slot_cnt != 8'hFF)
            slot_cnt <= slot_cnt + 8'd1;

         case (state)
            S_IDLE: begin
               if (sleep_cmd || pend_sleep || (en_schedule && lim != 5'd0)) begin
                  state <= S_LOAD;
                  busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (pend_sleep) begin
                  frame_id   <= DIAG_ID;
                  slot_len   <= eff_len(DIAG_SLOT);
                  slot_sleep <= 1'b1;
                  slot_diag  <= 1'b0;
                  pend_sleep <= 1'b0;
               end else if (pend_diag) begin
                  frame_id   <= DIAG_ID;
                  slot_len   <= eff_len(DIAG_SLOT);
                  slot_sleep <= 1'b0;
                  slot_diag  <= 1'b1;
                  pend_diag  <= 1'b0;
               end else begin
                  frame_id   <= entry[13:8];
                  slot_len   <= eff_len(entry[7:0]);
                  slot_sleep <= 1'b0;
                  slot_diag  <= 1'b0;
               end
               slot_cnt  <= '0;
               frame_req <= 1'b1;
               state     <= S_REQ;
            end
            S_REQ: begin
               if (frame_done) begin
                  frame_req <= 1'b0;
                  state     <= S_SLOT_WAIT;
               end else if (overrun_hit) begin
                  frame_req    <= 1'b0;
                  slot_overrun <= 1'b1;
               end
            end
            S_SLEEP: begin
               if (wakeup) begin
                  state     <= S_IDLE;
                  sleeping  <= 1'b0;
                  cur_index <= '0;
                  pend_diag <= 1'b0;
               end
            end
            default: ;
         endcase

         if (slot_end) begin
            if (slot_sleep) begin
               state    <= S_SLEEP;
               sleeping <= 1'b1;
               busy     <= 1'b0;
            end else if (!en_schedule) begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               cur_index <= '0;
            end else begin
               state <= S_LOAD;
               if (wrap)
                  cur_index <= '0;
               else if (!slot_diag)
                  cur_index <= cur_index + 4'd1;
            end
         end

         // new request pulses take precedence over a same-cycle clear
         if (diag_req)
            pend_diag <= 1'b1;
         if (sleep_cmd && state != S_SLEEP)
            pend_sleep <= 1'b1;
      end
   end

endmodule
